// File: rtl/lfsr_multistep.sv
// lfsr_multistep: XNOR Fibonacci LFSR advancing STEPS shifts per enabled clock, with seed load,
// lock-up trap, wrap pulse and period counter. Optional macro LFSR_TAPS_PORT_EN adds a runtime taps_in port.
`default_nettype none

module lfsr_multistep #(
  parameter int               WIDTH = 6,
  parameter int               STEPS = 3,
  parameter logic [WIDTH-1:0] TAPS  = 6'b110000,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
`ifdef LFSR_TAPS_PORT_EN
  input  logic [WIDTH-1:0] taps_in,
`endif
  output logic [WIDTH-1:0] y,
  output logic             wrap,
  output logic             lockup,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_start;
  logic             r_wrap;
  logic             r_lock;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_taps;
  logic [WIDTH-1:0] w_nxt;
  logic             w_nxt_lock;
  logic             w_seed_lock;
  logic             w_hit_start;

`ifdef LFSR_TAPS_PORT_EN
  assign w_taps = taps_in;
`else
  assign w_taps = TAPS;
`endif

  // STEPS single-bit shifts unrolled into one combinational cone
  always_comb begin
    w_nxt = r_y;
    for (int s = 0; s < STEPS; s++) begin
      w_nxt = {w_nxt[WIDTH-2:0], ~(^(w_nxt & w_taps))};
    end
  end

  assign w_nxt_lock  = (w_nxt == c_ONES);
  assign w_seed_lock = (seed == c_ONES);
  assign w_hit_start = (w_nxt == r_start);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y     <= '0;
      r_start <= '0;
      r_wrap  <= 1'b0;
      r_lock  <= 1'b0;
      r_cnt   <= '0;
    end else if (load) begin
      r_y     <= w_seed_lock ? '0 : seed;
      r_start <= w_seed_lock ? '0 : seed;
      r_lock  <= w_seed_lock;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else if (en) begin
      // all-ones is the XNOR dead state; force back to zero rather than stall forever
      r_y    <= w_nxt_lock ? '0 : w_nxt;
      r_lock <= w_nxt_lock;
      r_wrap <= w_hit_start;
      r_cnt  <= w_hit_start ? '0 : r_cnt + CNT_W'(1);
    end else begin
      r_wrap <= 1'b0;
      r_lock <= 1'b0;
    end
  end

  assign y      = r_y;
  assign wrap   = r_wrap;
  assign lockup = r_lock;
  assign cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_multistep.sv
// tb_lfsr_multistep: table vectors, hand sequences and random stimulus against an orbit-table model.
`default_nettype none

module tb_lfsr_multistep;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [5:0]  seed = '0;
  logic        en = 1'b0;
  logic [5:0]  y;
  logic        wrap;
  logic        lockup;
  logic [15:0] cnt;

  lfsr_multistep dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .en(en),
    .y(y), .wrap(wrap), .lockup(lockup), .cnt(cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the 63-state orbit of the default polynomial, indexed by position
  logic [5:0] seq [63];
  int         pos_of [64];
  int         m_y, m_start, m_cnt;
  bit         m_wrap, m_lock;

  typedef struct {
    bit         ld;
    logic [5:0] sd;
    bit         e;
    logic [5:0] ey;
    bit         ew;
    bit         el;
    int         ec;
  } vec_t;

  vec_t vecs [7];

  function automatic int step1(input int x);
    int fb;
    fb = (((x >> 5) & 1) == ((x >> 4) & 1)) ? 1 : 0;
    return ((x << 1) & 63) | fb;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y = 0; m_start = 0; m_cnt = 0; m_wrap = 0; m_lock = 0;
  endtask

  task automatic model_clock();
    int nxt;
    if (reset) begin
      model_reset();
    end else if (load) begin
      if (seed == 6'h3F) begin
        m_y = 0; m_start = 0; m_lock = 1;
      end else begin
        m_y = seed; m_start = seed; m_lock = 0;
      end
      m_cnt = 0; m_wrap = 0;
    end else if (en) begin
      nxt    = seq[(pos_of[m_y] + 3) % 63];
      m_wrap = (nxt == m_start);
      m_cnt  = m_wrap ? 0 : ((m_cnt + 1) & 16'hFFFF);
      m_y    = nxt;
      m_lock = 0;
    end else begin
      m_wrap = 0; m_lock = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".y"}, int'(y), m_y);
    chk({tag, ".wrap"}, int'(wrap), int'(m_wrap));
    chk({tag, ".lockup"}, int'(lockup), int'(m_lock));
    chk({tag, ".cnt"}, int'(cnt), m_cnt);
  endtask

  initial begin
    int x;
    for (int i = 0; i < 64; i++) pos_of[i] = -1;
    x = 0;
    for (int k = 0; k < 63; k++) begin
      seq[k] = x[5:0];
      pos_of[x] = k;
      x = step1(x);
    end
    model_reset();

    vecs[0] = '{0, 6'h00, 1, 6'h07, 0, 0, 1};
    vecs[1] = '{0, 6'h00, 1, 6'h3E, 0, 0, 2};
    vecs[2] = '{0, 6'h00, 0, 6'h3E, 0, 0, 2};
    vecs[3] = '{1, 6'h3F, 0, 6'h00, 0, 1, 0};
    vecs[4] = '{0, 6'h00, 1, 6'h07, 0, 0, 1};
    vecs[5] = '{1, 6'h15, 1, 6'h15, 0, 0, 0};
    vecs[6] = '{0, 6'h00, 0, 6'h15, 0, 0, 0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.y", int'(y), 0);
    chk("rst.cnt", int'(cnt), 0);
    chk("rst.wrap", int'(wrap), 0);
    chk("rst.lockup", int'(lockup), 0);
    reset = 1'b0;

    // table vectors
    for (int i = 0; i < 7; i++) begin
      load = vecs[i].ld; seed = vecs[i].sd; en = vecs[i].e;
      tick();
      chk($sformatf("vec%0d.y", i), int'(y), int'(vecs[i].ey));
      chk($sformatf("vec%0d.wrap", i), int'(wrap), int'(vecs[i].ew));
      chk($sformatf("vec%0d.lockup", i), int'(lockup), int'(vecs[i].el));
      chk($sformatf("vec%0d.cnt", i), int'(cnt), vecs[i].ec);
    end
    load = 1'b0;

    // asynchronous reset mid-cycle while running
    en = 1'b1;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async.y", int'(y), 0);
    chk("async.cnt", int'(cnt), 0);
    chk("async.wrap", int'(wrap), 0);
    chk("async.lockup", int'(lockup), 0);
    reset = 1'b0;

    // free run from zero: wrap every 21 cycles, never all-ones
    en = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      tick();
      chk("run.wrap", int'(wrap), (i % 21 == 0) ? 1 : 0);
      chk("run.not3F", (y == 6'h3F) ? 1 : 0, 0);
      if (i % 21 == 0) begin
        chk("run.wrap_y", int'(y), 0);
        chk("run.wrap_cnt", int'(cnt), 0);
      end
    end

    // hold with en low
    en = 1'b0;
    tick(); tick();
    compare_all("hold");

    // seeded run: wrap after 21 cycles back at the seed
    load = 1'b1; seed = 6'h15; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      chk("seed.wrap", int'(wrap), (i == 21) ? 1 : 0);
      if (i == 21) chk("seed.wrap_y", int'(y), 6'h15);
    end

    // random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(15) == 0);
      seed = ($urandom_range(3) == 0) ? 6'h3F : 6'($urandom);
      en   = ($urandom_range(3) != 0);
      tick();
      compare_all("rnd");
      if ($urandom_range(79) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all("rnd_async");
        reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lfsr_multistep.md
Name: lfsr_multistep

Overview:
- Parametrised XNOR Fibonacci LFSR that advances STEPS single-bit shifts per enabled clock, for parallel PN/scrambler data in the DSP datapath.
- Generalised in width, step count and tap polynomial.
- Adds seed load, enable, lock-up recovery, sequence-wrap detection and a period counter.

Parameters:
- WIDTH, 6, register length N (bits numbered N..1, bit N = MSB of y); 2..32.
- STEPS, 3, single-bit shifts per enabled cycle; 1..WIDTH.
- TAPS, 6'b110000, feedback mask; bit i-1 set means ff[i] enters the XNOR; WIDTH bits wide.
- CNT_W, 16, width of the period counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- load  in  1  load seed this cycle.
- seed  in  WIDTH  start state for load.
- en  in  1  advance STEPS shifts this cycle.
- y  out  WIDTH  LFSR state ff[N..1].
- wrap  out  1  one-cycle pulse: state has returned to start state.
- lockup  out  1  one-cycle pulse: illegal all-ones state trapped.
- cnt  out  CNT_W  enabled cycles since last start (reset/load/wrap).

Behaviour:
- Reset (async, active-high) clears y, wrap, lockup and cnt to 0. Start state = 0.
- Single-step function S(x): ff[i+1] <= ff[i] for i = 1..N-1; ff[1] <= XNOR of all ff[i] with TAPS[i-1] = 1.
- Enabled update: y <= S applied STEPS times to y. Fully unrolled combinationally, 1-cycle latency, no pipeline bubbles.
- Priority: reset > load > en > hold.
- load=1:
  - y <= seed; start state <= seed; cnt <= 0; wrap = 0.
  - If seed is all-ones (the XNOR lock-up state), y <= 0, start state <= 0 and lockup = 1 for that cycle.
- en=1, load=0:
  - Compute nxt = S^STEPS(y).
  - If nxt is all-ones (only possible with a non-primitive TAPS), y <= 0 and lockup = 1.
  - If nxt == start state, wrap = 1 and cnt <= 0; otherwise cnt <= cnt+1.
  - cnt wraps modulo 2^CNT_W silently.
- en=0, load=0: y and cnt hold; wrap = 0; lockup = 0.
- wrap and lockup are registered pulses, asserted in the same cycle y shows the new state.
- load and en both high: load wins and en is ignored.
- Reset mid-sequence: immediate return to 0 with all pulses cleared; the next en restarts the sequence from 0.
- For a primitive TAPS, wrap period in cycles = (2^N - 1) / gcd(STEPS, 2^N - 1).

Optional Feature:
- Macro LFSR_TAPS_PORT_EN.
- Defined:
  - Adds input port taps_in [WIDTH], sampled every cycle, replacing TAPS in S().
  - Tap changes take effect on the next enabled or loaded update.
  - lockup detection stays active.
- Undefined: no taps_in port; TAPS parameter is fixed at elaboration.

Test Plan:
- Defaults, reset then en=1 for 2 cycles -> y = 6'h07, then 6'h3E; cnt = 1, 2; wrap = 0; lockup = 0.
- Defaults, reset then en=1 held -> wrap pulses on cycle 21 with y = 0 and cnt = 0; repeats every 21 cycles; no 6'h3F is ever seen.
- Load seed = 6'h3F -> y = 0, lockup = 1 for one cycle; next en gives y = 6'h07.
- Load seed = 6'h15, then en held -> wrap after 21 cycles with y = 6'h15; load and en together in one cycle -> y = seed, cnt = 0.
- Assert reset asynchronously mid-cycle during a run -> y, cnt, wrap and lockup go to 0 immediately without waiting for a clock; en toggled low -> y and cnt hold.
- STEPS=1, WIDTH=4, TAPS=4'b1100 -> wrap period 15 cycles.
- With LFSR_TAPS_PORT_EN, WIDTH=4, taps_in = 4'b1111 (non-primitive) -> lockup pulse observed or period differs from 15; no cycle ever shows 4'hF on y.
